param_frame_deserializer: RTL
=============================

// Module: param_frame_deserializer
// PURPOSE
//   Parametrised successor of the nibble-to-byte deserializer. Packs IN_W-bit input
//   beats into OUT_W-bit words and interleaves N_CH words per group (ch0,ch1,...).
//   Delimits frames of FRAME_GROUPS groups, with optional sync-word frame alignment.
//   Output uses a valid/ready handshake in the single input clock domain, with no
//   derived clock. Sits between the serial front-end and the pixel/line formatter.
// PARAMETERS
//   IN_W          4      input beat width; OUT_W % IN_W == 0 (elaboration $error otherwise)
//   OUT_W         8      channel word width
//   N_CH          2      channels per group (>=1); 2 reproduces even/odd pairing
//   FRAME_GROUPS  324    groups per frame (>=1)
//   MSB_FIRST     1      1: first beat of a word -> word MSBs; 0: -> LSBs
//   SYNC_EN       0      1: hunt for SYNC_WORD before every frame; 0: free-run frames
//   SYNC_WORD     8'hA5  OUT_W-bit sync pattern (compared after MSB_FIRST ordering)
// PORTS
//   clk_75mhz    in   1           sole clock, rising edge
//   rst          in   1           async assert, active-high; release synchronous to clk
//   enable       in   1           1: data_in consumed this cycle; 0: stall (state held)
//   data_in      in   IN_W        input beat
//   out_data     out  N_CH*OUT_W  group; ch k at [k*OUT_W +: OUT_W]
//   out_valid    out  1           group available; held until out_ready
//   out_ready    in   1           consumer accept
//   frame_start  out  1           qualifies out_valid: group is first of frame
//   frame_end    out  1           qualifies out_valid: group is last of frame
//   frame_cnt    out  16          completed frames, wraps 16'hFFFF -> 0
//   locked       out  1           1 when state == RUN
//   overflow     out  1           sticky; group dropped due to backpressure
// BEHAVIOUR
//   - Reset: out_data/out_valid/frame_start/frame_end/frame_cnt/overflow = 0;
//     beat, word and group counters = 0; state = SYNC_EN ? HUNT : RUN; locked = !SYNC_EN.
//   - Counters: beat 0..OUT_W/IN_W-1, word 0..N_CH-1, group 0..FRAME_GROUPS-1.
//     All advance only on enable=1; enable=0 freezes everything except the handshake.
//   - HUNT: shift register of the last OUT_W/IN_W beats; on match with SYNC_WORD,
//     go to RUN with counters zeroed. The sync beats are not output, and the next
//     beat is beat 0 of group 0. Partial matches spanning enable gaps still count.
//   - RUN: beat fills word[word_cnt]. Group completes on the last beat of word N_CH-1.
//   - Latency: out_valid rises on the edge after the completing beat's edge.
//     frame_start = (group==0) and frame_end = (group==FRAME_GROUPS-1) are latched
//     with out_data. FRAME_GROUPS=1 asserts both on the same group.
//   - Handshake: transfer when out_valid && out_ready. out_data and flags stay stable
//     while out_valid && !out_ready.
//   - Completion with out_valid=0, or out_valid && out_ready in the same cycle:
//     new group loads and out_valid stays 1. No gap and no overflow.
//   - Completion with out_valid && !out_ready: new group discarded and overflow <= 1.
//     Group counter still advances, so frame alignment is preserved.
//   - Last group of a frame completes: frame_cnt += 1 (even if dropped). Group
//     counter -> 0. If SYNC_EN, state -> HUNT and locked drops next cycle.
//   - Any rst assertion mid-word or mid-frame: partial data discarded immediately,
//     including a pending out_valid. overflow is cleared only by rst.
// TESTING
//   1 defaults, FRAME_GROUPS=3, beats 1,2,3,4 -> out_data=16'h3412, out_valid 1 cycle after beat 4, frame_start=1
//   2 12 beats continuous, out_ready=1 -> 3 valids 4 cycles apart; frame_end on 3rd; frame_cnt=1; overflow=0
//   3 out_ready=0 across 2 completions -> 1st group held stable, 2nd dropped, overflow=1 until rst
//   4 SYNC_EN=1, beats 0,A,5,6,7,8,9 -> locked rises after 5; out_data=16'h8967; locked=0 after frame_end
//   5 enable toggled 1/0 every cycle on test 1 data -> identical out_data, completion on 4th enabled beat
//   6 rst pulse after beat 3 of a group, then beats 1,2,3,4 -> out_data=16'h3412, frame_start=1, no stale valid

Source files
------------

// File: rtl/param_frame_deserializer.sv
// ---------------------------------------------------------------------------
// param_frame_deserializer
//   Packs IN_W-bit input beats into OUT_W-bit channel words. N_CH words
//   (ch0, ch1, ...) form one group, and FRAME_GROUPS groups form one frame.
//   With SYNC_EN set, a SYNC_WORD pattern must be found in the beat stream
//   before each frame. Groups are presented on a valid/ready port in the
//   single input clock domain.
//
// Ports
//   clk_75mhz    in   sole clock, rising edge
//   rst          in   async assert, active-high
//   enable       in   data_in consumed this cycle; 0 stalls (handshake still runs)
//   data_in      in   IN_W-bit input beat
//   out_data     out  group; ch k at [k*OUT_W +: OUT_W]
//   out_valid    out  group available, held until out_ready
//   out_ready    in   consumer accept
//   frame_start  out  with out_valid: group is first of frame
//   frame_end    out  with out_valid: group is last of frame
//   frame_cnt    out  completed frames (wraps)
//   locked       out  1 while in RUN
//   overflow     out  sticky: a group was dropped under backpressure
// ---------------------------------------------------------------------------
module param_frame_deserializer #(
  parameter int               IN_W         = 4,
  parameter int               OUT_W        = 8,
  parameter int               N_CH         = 2,
  parameter int               FRAME_GROUPS = 324,
  parameter int               MSB_FIRST    = 1,
  parameter int               SYNC_EN      = 0,
  parameter logic [OUT_W-1:0] SYNC_WORD    = 'hA5
) (
  input  logic                   clk_75mhz,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [IN_W-1:0]        data_in,
  output logic [N_CH*OUT_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic [15:0]            frame_cnt,
  output logic                   locked,
  output logic                   overflow
);

  localparam int BPW   = OUT_W / IN_W;
  localparam int GRP_W = N_CH * OUT_W;
  localparam int BW    = (BPW > 1)          ? $clog2(BPW)          : 1;
  localparam int WW    = (N_CH > 1)         ? $clog2(N_CH)         : 1;
  localparam int GW    = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;
  localparam int PW    = (GRP_W > 1)        ? $clog2(GRP_W)        : 1;

  generate
    if (OUT_W % IN_W != 0) begin : g_bad_width
      $error("param_frame_deserializer: OUT_W must be a multiple of IN_W");
    end
    if (N_CH < 1) begin : g_bad_nch
      $error("param_frame_deserializer: N_CH must be >= 1");
    end
    if (FRAME_GROUPS < 1) begin : g_bad_fg
      $error("param_frame_deserializer: FRAME_GROUPS must be >= 1");
    end
  endgenerate

  typedef enum logic {ST_HUNT, ST_RUN} state_t;

  state_t             r_state;
  logic [BW-1:0]      r_beat;
  logic [WW-1:0]      r_word;
  logic [GW-1:0]      r_grp;
  logic [GRP_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_sync;

  logic               w_last_beat;
  logic               w_last_word;
  logic               w_last_grp;
  logic               w_grp_done;
  logic               w_xfer;
  logic               w_sync_hit;
  logic [BW-1:0]      w_slot;
  logic [PW-1:0]      w_pos;
  logic [OUT_W-1:0]   w_sync_next;
  logic [GRP_W-1:0]   w_acc_next;

  assign w_last_beat = (r_beat == BW'(BPW - 1));
  assign w_last_word = (r_word == WW'(N_CH - 1));
  assign w_last_grp  = (r_grp  == GW'(FRAME_GROUPS - 1));
  assign w_grp_done  = enable && (r_state == ST_RUN) && w_last_beat && w_last_word;
  assign w_xfer      = out_valid && out_ready;

  // Beat slot inside the current word: with MSB_FIRST the first beat lands
  // in the top slot, so the slot index counts down as beats arrive.
  assign w_slot = (MSB_FIRST != 0) ? (BW'(BPW - 1) - r_beat) : r_beat;
  assign w_pos  = PW'(r_word) * PW'(OUT_W) + PW'(w_slot) * PW'(IN_W);

  // Group accumulator with the current beat merged in; on the completing
  // beat this is the full group that gets loaded into out_data.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[w_pos +: IN_W] = data_in;
  end

  // Sync window holds the last BPW beats in the same ordering a data word
  // would have, so SYNC_WORD is compared directly as a channel word.
  generate
    if (MSB_FIRST != 0) begin : g_sync_msb
      assign w_sync_next = (r_sync << IN_W) | OUT_W'(data_in);
    end else begin : g_sync_lsb
      assign w_sync_next = (r_sync >> IN_W) | (OUT_W'(data_in) << (OUT_W - IN_W));
    end
  endgenerate

  assign w_sync_hit = enable && (r_state == ST_HUNT) && (w_sync_next == SYNC_WORD);

  always_ff @(posedge clk_75mhz or posedge rst) begin
    if (rst) begin
      r_state     <= (SYNC_EN != 0) ? ST_HUNT : ST_RUN;
      locked      <= (SYNC_EN == 0);
      r_beat      <= '0;
      r_word      <= '0;
      r_grp       <= '0;
      r_acc       <= '0;
      r_sync      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_cnt   <= '0;
      overflow    <= 1'b0;
    end else begin
      // Output side: a transfer frees the register; a completing group may
      // refill it in the same cycle, giving back-to-back valids with no gap.
      if (w_xfer) out_valid <= 1'b0;
      if (w_grp_done) begin
        if (!out_valid || out_ready) begin
          out_data    <= w_acc_next;
          out_valid   <= 1'b1;
          frame_start <= (r_grp == '0);
          frame_end   <= w_last_grp;
        end else begin
          // Held group wins; the new one is lost but counters keep moving
          // so frame boundaries stay aligned.
          overflow <= 1'b1;
        end
      end

      case (r_state)
        ST_HUNT: begin
          if (enable) begin
            r_sync <= w_sync_next;
            if (w_sync_hit) begin
              r_state <= ST_RUN;
              locked  <= 1'b1;
              r_beat  <= '0;
              r_word  <= '0;
              r_grp   <= '0;
              r_sync  <= '0;
            end
          end
        end
        ST_RUN: begin
          if (enable) begin
            r_acc <= w_acc_next;
            if (!w_last_beat) begin
              r_beat <= r_beat + BW'(1);
            end else begin
              r_beat <= '0;
              if (!w_last_word) begin
                r_word <= r_word + WW'(1);
              end else begin
                r_word <= '0;
                if (!w_last_grp) begin
                  r_grp <= r_grp + GW'(1);
                end else begin
                  r_grp     <= '0;
                  frame_cnt <= frame_cnt + 16'd1;
                  if (SYNC_EN != 0) begin
                    r_state <= ST_HUNT;
                    locked  <= 1'b0;
                    r_sync  <= '0;
                  end
                end
              end
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule
